// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the multiplexed BCD display scanner.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_display_scanner_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry k holds the pattern for decimal digit k.
  localparam logic [9:0][6:0] SEG_CODES = {
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
// Non-decimal inputs render as a dash.
module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (digit <= 4'd9)
      seg = SEG_CODES[digit];
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit time-multiplexed display driver with
// digit latch, refresh prescaler and leading-zero blanking.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt;
  logic [1:0] idx;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0] cur;
  logic [6:0] code;
  logic tick;
  logic wrap;
  logic blank;

  assign tick = (pcnt == PMAX);
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      idx    <= '0;
      digits <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick)
        idx <= idx + 2'd1;
      if (load)
        digits <= {thousands, hundreds, tens, ones};
    end
  end

  // lz[i]: digit i and everything above it are zero.
  always_comb begin
    lz    = '0;
    lz[3] = (digits[3] == 4'd0);
    lz[2] = lz[3] && (digits[2] == 4'd0);
    lz[1] = lz[2] && (digits[1] == 4'd0);
    lz[0] = 1'b0;
    cur   = digits[idx];
    blank = BLANK_LZ && lz[idx];
  end

  bcd_to_seg7 u_dec (
    .digit (cur),
    .seg   (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      anode      <= 4'b1111;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_sel(idx);
      seg        <= blank ? SEG_BLANK : code;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner, REFRESH_DIV=4,
// with blanking enabled (a) and disabled (b).
module tb_bcd_display_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       load;
  logic [3:0] thousands, hundreds, tens, ones;
  logic [3:0] anode_a, anode_b;
  logic [6:0] seg_a, seg_b;
  logic       fd_a, fd_b;

  int n;
  int checks = 0;
  int fails  = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  // {thousands, hundreds, tens, ones}
  localparam logic [3:0][6:0] IDLE_A = {SB, SB, SB, S0};
  localparam logic [3:0][6:0] IDLE_B = {S0, S0, S0, S0};
  localparam logic [3:0][6:0] V1234  = {S1, S2, S3, S4};
  localparam logic [3:0][6:0] V50_A  = {SB, SB, S5, S0};
  localparam logic [3:0][6:0] V50_B  = {S0, S0, S5, S0};
  localparam logic [3:0][6:0] VC_A   = {SB, SB, SB, SD};
  localparam logic [3:0][6:0] VC_B   = {S0, S0, S0, SD};
  localparam logic [3:0][6:0] V9876  = {S9, S8, S7, S6};

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .thousands  (thousands),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .anode      (anode_a),
    .seg        (seg_a),
    .frame_done (fd_a)
  );

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .thousands  (thousands),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .anode      (anode_b),
    .seg        (seg_b),
    .frame_done (fd_b)
  );

  // n counts edges since reset release; n=1 is the first free edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) n = 0;
    else n++;
  endtask

  task automatic chk4(input string tag, input logic [3:0] got,
                      input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s n=%0d got %b want %b", tag, n, got, want);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] got,
                      input logic [6:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s n=%0d got %b want %b", tag, n, got, want);
    end
  endtask

  task automatic chk1(input string tag, input logic got,
                      input logic want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s n=%0d got %b want %b", tag, n, got, want);
    end
  endtask

  task automatic check_cycle(input string tag,
                             input logic [3:0][6:0] ea,
                             input logic [3:0][6:0] eb);
    int i;
    logic [3:0] an;
    logic fd;
    i  = ((n - 1) / 4) % 4;
    an = ~(4'b0001 << i);
    fd = (n % 16 == 0);
    chk4({tag, "_anode_a"}, anode_a, an);
    chk4({tag, "_anode_b"}, anode_b, an);
    chk7({tag, "_seg_a"}, seg_a, ea[i]);
    chk7({tag, "_seg_b"}, seg_b, eb[i]);
    chk1({tag, "_fd_a"}, fd_a, fd);
    chk1({tag, "_fd_b"}, fd_b, fd);
  endtask

  task automatic run(input string tag, input logic [3:0][6:0] ea,
                     input logic [3:0][6:0] eb, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step();
      check_cycle(tag, ea, eb);
    end
  endtask

  task automatic check_reset(input string tag);
    chk4({tag, "_anode_a"}, anode_a, 4'b1111);
    chk4({tag, "_anode_b"}, anode_b, 4'b1111);
    chk7({tag, "_seg_a"}, seg_a, SB);
    chk7({tag, "_seg_b"}, seg_b, SB);
    chk1({tag, "_fd_a"}, fd_a, 1'b0);
  endtask

  // One load edge, then scramble the inputs to prove the latch holds.
  task automatic load_digits(input logic [3:0] t, input logic [3:0] h,
                             input logic [3:0] te, input logic [3:0] o);
    thousands = t;
    hundreds  = h;
    tens      = te;
    ones      = o;
    load      = 1'b1;
    step();
    load      = 1'b0;
    thousands = 4'h7;
    hundreds  = 4'hE;
    tens      = 4'h9;
    ones      = 4'h3;
  endtask

  initial begin
    n = 0;
    rst = 1'b1;
    load = 1'b1;
    thousands = 4'h1;
    hundreds  = 4'h1;
    tens      = 4'h1;
    ones      = 4'h1;
    step();
    step();
    check_reset("reset");
    rst  = 1'b0;
    load = 1'b0;

    run("idle", IDLE_A, IDLE_B, 40);

    load_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run("d1234", V1234, V1234, 32);

    load_digits(4'd0, 4'd0, 4'd5, 4'd0);
    run("d0050", V50_A, V50_B, 16);

    load_digits(4'd0, 4'd0, 4'd0, 4'hC);
    run("dash", VC_A, VC_B, 16);

    // Load on the index 3->0 wrap edge.
    while (n % 16 != 15) begin
      step();
      check_cycle("prewrap", VC_A, VC_B);
    end
    thousands = 4'd9;
    hundreds  = 4'd8;
    tens      = 4'd7;
    ones      = 4'd6;
    load      = 1'b1;
    step();
    check_cycle("wrapedge", VC_A, VC_B);
    load = 1'b0;
    run("d9876", V9876, V9876, 20);

    // Reset mid-scan while index 2 is active.
    while (!((n / 4) % 4 == 2 && n % 4 == 1)) begin
      step();
      check_cycle("pre_rst", V9876, V9876);
    end
    rst = 1'b1;
    step();
    check_reset("midrst");
    rst = 1'b0;
    run("post_rst", IDLE_A, IDLE_B, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter SHALL be: REFRESH_DIV, 100000, clock cycles each digit is held before the scan advances (legal range >= 2).
REQ-002 Parameter SHALL be: BLANK_LZ, 1, enables leading-zero blanking when 1.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port SHALL be: clk  input  1  system clock, all state on rising edge.
REQ-005 Port SHALL be: rst  input  1  synchronous active-high reset.
REQ-006 Port SHALL be: load  input  1  capture strobe for the four digit inputs.
REQ-007 Port SHALL be: thousands, hundreds, tens, ones  input  4 each  BCD digits from the binary-to-BCD stage.
REQ-008 Port SHALL be: anode  output  4  active-low digit enables; bit0 = ones (rightmost), bit3 = thousands.
REQ-009 Port SHALL be: seg  output  7  active-low segments ordered {g,f,e,d,c,b,a}.
REQ-010 Port SHALL be: frame_done  output  1  one-cycle pulse per completed 4-digit scan.

Function
REQ-011 Digit latch: when load=1 at a clock edge, all four inputs SHALL be captured together; when load=0, the latch SHALL hold.
REQ-012 Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0; it SHALL run freely and SHALL NOT be affected by load.
REQ-013 Scan index: 2 bits; advances 0->1->2->3->0 on each edge where prescaler = REFRESH_DIV-1; index 0 = ones.
REQ-014 anode and seg SHALL be registered, computed each cycle from the current index and latch, giving 1 cycle latency from any index or latch change.
REQ-015 anode SHALL drive exactly one bit low (the bit for the current index) at all times outside reset.
REQ-016 Decode codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 A digit value of 10..15 SHALL display a dash: 0111111.
REQ-018 With BLANK_LZ=1: a digit SHALL show 1111111 when it and all more-significant digits are 0; the ones digit SHALL never be blanked.
REQ-019 With BLANK_LZ=0: no digit SHALL be blanked.
REQ-020 Blanking SHALL be evaluated on the latched values only; an invalid digit counts as nonzero.
REQ-021 frame_done SHALL be registered and high for exactly the one cycle after the index wraps 3->0.
REQ-022 load coinciding with an index advance: both SHALL take effect; the next output SHALL use the new index with the new digits.

Reset
REQ-023 While rst=1 (priority over load): prescaler=0, index=0, latch=0, anode=1111, seg=1111111, frame_done=0.
REQ-024 On the first edge after rst falls: anode=1110, seg=1000000 (ones shows 0, all other digits blanked).
REQ-025 Reset asserted mid-scan SHALL abandon the scan and restart from index 0 with a full REFRESH_DIV period.

Structure
REQ-026 The shared package SHALL hold the ten segment codes, SEG_DASH, SEG_BLANK, and NUM_DIGITS=4.
REQ-027 Decode SHALL be a combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out), used once on the muxed digit.

Verification (REFRESH_DIV=4)
REQ-028 Reset release, no load -> anode=1110 and seg=1000000 held indefinitely across scans, with other anodes showing 1111111.
REQ-029 Load T/H/T/O=1/2/3/4 -> each step held 4 cycles, in this order: 1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001, then repeat.
REQ-030 Load 0/0/5/0 -> thousands and hundreds 1111111, tens 0010010, ones 1000000; with BLANK_LZ=0, thousands and hundreds show 1000000.
REQ-031 Load ones=4'hC, others 0 -> ones shows 0111111; tens, hundreds and thousands blanked.
REQ-032 Free run -> frame_done pulses 1 cycle every 16 cycles; load at the index-3 wrap edge -> new digits appear at the index-0 output.
REQ-033 rst pulse while index=2 -> the next edge gives anode=1111 and seg=1111111, then the REQ-024 values, and the first advance 4 cycles later.
